// File: rtl/lcd_ctrl.sv
// HD44780-style character-LCD sequencer.
// Runs the power-up wait and fixed init command list after reset, then
// accepts one command/data byte at a time over a valid/ready handshake and
// expands it into a timed setup / EN pulse / hold / execution-wait transfer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_POWERUP  | power-up wait, ON=1, bus idle (held while reset asserted)
// S_SETUP    | RS/DATA driven, EN=0
// S_PULSE    | EN=1, RS/DATA unchanged
// S_HOLD     | EN=0, RS/DATA held after EN falls
// S_WAIT     | execution wait (long for clear/home commands)
// S_IDLE     | ready for a request, bus keeps last RS/DATA with EN=0
module lcd_ctrl #(
   parameter int POWERUP_CYC   = 20,
   parameter int SETUP_CYC     = 2,
   parameter int PULSE_CYC     = 4,
   parameter int HOLD_CYC      = 2,
   parameter int WAIT_CYC      = 8,
   parameter int WAIT_LONG_CYC = 32
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_vld,
   input  logic        i_req_rs,
   input  logic [7:0]  i_req_data,
   output logic        o_req_rdy,
   output logic        o_busy,
   output logic        o_init_done,
   output logic [31:0] o_io_lcd
);

   localparam int MAX_A = (POWERUP_CYC > SETUP_CYC) ? POWERUP_CYC : SETUP_CYC;
   localparam int MAX_B = (PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC;
   localparam int MAX_C = (WAIT_CYC > WAIT_LONG_CYC) ? WAIT_CYC : WAIT_LONG_CYC;
   localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_P = (MAX_C > MAX_D) ? MAX_C : MAX_D;
   localparam int CW    = $clog2(MAX_P + 1);

   typedef enum logic [2:0] {
      S_POWERUP,
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_WAIT,
      S_IDLE
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_init_idx;
   logic            r_init_done;
   logic            r_on;
   logic            r_rs;
   logic [7:0]      r_data;

   state_t          w_state_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [1:0]      w_init_idx_nxt;
   logic            w_init_done_nxt;
   logic            w_rs_nxt;
   logic [7:0]      w_data_nxt;
   logic            w_tc;
   logic            w_long;
   logic [CW-1:0]   w_wait_load;
   logic            w_en;

   function automatic logic [7:0] init_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    init_byte = 8'h38;
         2'd1:    init_byte = 8'h0C;
         2'd2:    init_byte = 8'h01;
         default: init_byte = 8'h06;
      endcase
   endfunction

   // Each state lasts exactly its loaded count: leave when the counter reads 1.
   assign w_tc        = (r_cnt == CW'(1));
   // Clear (0x01) and home (0x02/0x03) commands need the long execution wait.
   assign w_long      = !r_rs && (r_data inside {8'h01, 8'h02, 8'h03});
   assign w_wait_load = w_long ? CW'(WAIT_LONG_CYC) : CW'(WAIT_CYC);

   // Next-state, counter reload and byte latching.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_init_idx_nxt  = r_init_idx;
      w_init_done_nxt = r_init_done;
      w_rs_nxt        = r_rs;
      w_data_nxt      = r_data;

      // r_on is low only in the cycle(s) right after reset, so the power-up
      // count starts with the first edge that sees reset released.
      if (r_on && (r_state != S_IDLE) && !w_tc) begin
         w_cnt_nxt = r_cnt - CW'(1);
      end

      case (r_state)
         S_POWERUP: begin
            if (r_on && w_tc) begin
               w_state_nxt    = S_SETUP;
               w_cnt_nxt      = CW'(SETUP_CYC);
               w_init_idx_nxt = 2'd0;
               w_rs_nxt       = 1'b0;
               w_data_nxt     = init_byte(2'd0);
            end
         end
         S_SETUP: begin
            if (w_tc) begin
               w_state_nxt = S_PULSE;
               w_cnt_nxt   = CW'(PULSE_CYC);
            end
         end
         S_PULSE: begin
            if (w_tc) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = CW'(HOLD_CYC);
            end
         end
         S_HOLD: begin
            if (w_tc) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = w_wait_load;
            end
         end
         S_WAIT: begin
            if (w_tc) begin
               if (r_init_done) begin
                  w_state_nxt = S_IDLE;
               end else if (r_init_idx == 2'd3) begin
                  w_state_nxt     = S_IDLE;
                  w_init_done_nxt = 1'b1;
               end else begin
                  w_state_nxt    = S_SETUP;
                  w_cnt_nxt      = CW'(SETUP_CYC);
                  w_init_idx_nxt = r_init_idx + 2'd1;
                  w_rs_nxt       = 1'b0;
                  w_data_nxt     = init_byte(r_init_idx + 2'd1);
               end
            end
         end
         S_IDLE: begin
            if (i_req_vld) begin
               w_state_nxt = S_SETUP;
               w_cnt_nxt   = CW'(SETUP_CYC);
               w_rs_nxt    = i_req_rs;
               w_data_nxt  = i_req_data;
            end
         end
         default: begin
            w_state_nxt = S_POWERUP;
            w_cnt_nxt   = CW'(POWERUP_CYC);
         end
      endcase
   end

   // State, counter and bus registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state     <= S_POWERUP;
         r_cnt       <= CW'(POWERUP_CYC);
         r_init_idx  <= 2'd0;
         r_init_done <= 1'b0;
         r_on        <= 1'b0;
         r_rs        <= 1'b0;
         r_data      <= 8'h00;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_init_idx  <= w_init_idx_nxt;
         r_init_done <= w_init_done_nxt;
         r_on        <= 1'b1;
         r_rs        <= w_rs_nxt;
         r_data      <= w_data_nxt;
      end
   end

   assign w_en        = (r_state == S_PULSE);
   assign o_req_rdy   = (r_state == S_IDLE);
   assign o_busy      = (r_state != S_IDLE);
   assign o_init_done = r_init_done;
   assign o_io_lcd    = {r_on, 20'd0, r_rs, 1'b0, w_en, r_data};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Testbench for lcd_ctrl: a cycle-by-cycle expected trace of the LCD bus and
// handshake outputs is built from the byte timing rules and compared at
// every falling edge.
module tb_lcd_ctrl;

   localparam int POWERUP_CYC   = 20;
   localparam int SETUP_CYC     = 2;
   localparam int PULSE_CYC     = 4;
   localparam int HOLD_CYC      = 2;
   localparam int WAIT_CYC      = 8;
   localparam int WAIT_LONG_CYC = 32;

   logic        clk;
   logic        rst_n;
   logic        vld;
   logic        req_rs;
   logic [7:0]  req_data;
   logic        rdy;
   logic        busy;
   logic        done;
   logic [31:0] lcd;

   lcd_ctrl #(
      .POWERUP_CYC  (POWERUP_CYC),
      .SETUP_CYC    (SETUP_CYC),
      .PULSE_CYC    (PULSE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .WAIT_CYC     (WAIT_CYC),
      .WAIT_LONG_CYC(WAIT_LONG_CYC)
   ) dut (
      .i_clk      (clk),
      .i_reset    (rst_n),
      .i_req_vld  (vld),
      .i_req_rs   (req_rs),
      .i_req_data (req_data),
      .o_req_rdy  (rdy),
      .o_busy     (busy),
      .o_init_done(done),
      .o_io_lcd   (lcd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] lcd;
      logic        rdy;
      logic        done;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          rise_last = -1;
   int          rise_prev = -1;
   logic        prev_en = 1'b0;
   logic        m_rs = 1'b0;
   logic [7:0]  m_data = 8'h00;
   logic        m_done = 1'b0;
   logic [7:0]  init_list [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

   function automatic logic [31:0] bus(input logic rs, input logic en, input logic [7:0] d);
      return 32'h8000_0000 | (32'(rs) << 10) | (32'(en) << 8) | 32'(d);
   endfunction

   task automatic push(input logic [31:0] l, input logic r);
      exp_t e;
      e.lcd  = l;
      e.rdy  = r;
      e.done = m_done;
      q.push_back(e);
   endtask

   task automatic push_idle();
      push(bus(m_rs, 1'b0, m_data), 1'b1);
   endtask

   // One byte transfer: setup, EN pulse, hold, execution wait.
   task automatic push_xfer(input logic rs, input logic [7:0] d);
      int w;
      m_rs   = rs;
      m_data = d;
      w = (!rs && d >= 8'h01 && d <= 8'h03) ? WAIT_LONG_CYC : WAIT_CYC;
      repeat (SETUP_CYC)    push(bus(rs, 1'b0, d), 1'b0);
      repeat (PULSE_CYC)    push(bus(rs, 1'b1, d), 1'b0);
      repeat (HOLD_CYC + w) push(bus(rs, 1'b0, d), 1'b0);
   endtask

   task automatic push_init();
      m_rs   = 1'b0;
      m_data = 8'h00;
      m_done = 1'b0;
      repeat (POWERUP_CYC) push(32'h8000_0000, 1'b0);
      for (int k = 0; k < 4; k++) push_xfer(1'b0, init_list[k]);
      m_done = 1'b1;
   endtask

   task automatic check_out(input string tag, input logic [34:0] exp);
      n_cmp++;
      assert ({lcd, rdy, busy, done} === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d observed lcd=%h rdy=%b busy=%b done=%b expected lcd=%h rdy=%b busy=%b done=%b",
                tag, cyc, lcd, rdy, busy, done, exp[34:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Compare n cycles against the head of the expected trace, then advance.
   task automatic consume(input string tag, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         if (q.size() > 0) begin
            e = q.pop_front();
            check_out(tag, {e.lcd, e.rdy, ~e.rdy, e.done});
         end
         if (lcd[8] && !prev_en) begin
            rise_prev = rise_last;
            rise_last = cyc;
         end
         prev_en = lcd[8];
         cyc++;
         @(negedge clk);
      end
   endtask

   // Called at a falling edge in the first IDLE cycle; returns likewise.
   task automatic send(input string tag, input logic rs, input logic [7:0] d, input int gap);
      repeat (gap) begin
         push_idle();
         consume(tag, 1);
      end
      push_idle();
      vld      = 1'b1;
      req_rs   = rs;
      req_data = d;
      consume(tag, 1);
      vld      = 1'b0;
      req_rs   = 1'($urandom);
      req_data = 8'($urandom);
      push_xfer(rs, d);
      consume(tag, q.size());
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       rs;
      logic [7:0] d;
      rst_n    = 1'b0;
      vld      = 1'b0;
      req_rs   = 1'b0;
      req_data = 8'h00;
      repeat (3) @(negedge clk);

      check_out("reset_state", {32'h0000_0000, 1'b0, 1'b1, 1'b0});

      // Release with a data request already pending; it must wait for init.
      rst_n    = 1'b1;
      vld      = 1'b1;
      req_rs   = 1'b1;
      req_data = 8'h55;
      @(negedge clk);
      push_init();
      push_idle();
      consume("init_seq", q.size());
      vld      = 1'b0;
      req_data = 8'hA5;
      push_xfer(1'b1, 8'h55);
      consume("pending_55", q.size());

      send("data_41", 1'b1, 8'h41, 0);
      check_out("idle_after_41", {32'h8000_0441, 1'b1, 1'b0, 1'b1});

      send("clear_01", 1'b0, 8'h01, 2);
      send("home_02", 1'b0, 8'h02, 1);
      send("data_rs1_01", 1'b1, 8'h01, 0);

      // Request held continuously across two bytes.
      push_idle();
      vld      = 1'b1;
      req_rs   = 1'b1;
      req_data = 8'h48;
      consume("b2b_48", 1);
      req_data = 8'h49;
      push_xfer(1'b1, 8'h48);
      consume("b2b_48", q.size());
      push_idle();
      consume("b2b_49", 1);
      vld = 1'b0;
      push_xfer(1'b1, 8'h49);
      consume("b2b_49", q.size());
      n_cmp++;
      assert ((rise_last - rise_prev) === 17) else begin
         n_err++;
         $error("FAIL b2b_spacing observed=%0d expected=17", rise_last - rise_prev);
      end

      for (int k = 0; k < 20; k++) begin
         rs = 1'($urandom_range(0, 1));
         d  = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            rs = 1'b0;
            d  = 8'($urandom_range(1, 3));
         end
         send("random", rs, d, $urandom_range(0, 3));
      end

      // Reset while EN is high in a data transfer.
      push_idle();
      vld      = 1'b1;
      req_rs   = 1'b1;
      req_data = 8'h5A;
      consume("mid_reset_xfer", 1);
      vld = 1'b0;
      push_xfer(1'b1, 8'h5A);
      consume("mid_reset_xfer", SETUP_CYC + 1);
      q.delete();
      n_cmp++;
      assert (lcd[8] === 1'b1) else begin
         n_err++;
         $error("FAIL en_before_reset observed=%b expected=1", lcd[8]);
      end
      rst_n = 1'b0;
      @(negedge clk);
      check_out("mid_reset_state", {32'h0000_0000, 1'b0, 1'b1, 1'b0});
      rst_n = 1'b1;
      @(negedge clk);
      push_init();
      push_idle();
      consume("reinit_seq", q.size());
      check_out("reinit_idle", {32'h8000_0006, 1'b1, 1'b0, 1'b1});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

HD44780-style character-LCD sequencer that drives the `o_io_lcd` output of the pipelined core.

- On reset release it runs the power-up wait and the fixed initialisation command sequence.
- After that it accepts one byte at a time (command or data) from the MEM-stage store path through a valid/ready handshake.
- It expands each byte into a timed setup / enable-pulse / hold / execution-wait transfer, so the pipeline never handles LCD timing.

## Interface

Parameters (all ≥ 1; values in `i_clk` cycles):
- `POWERUP_CYC`, 20, power-up wait before the first init command
- `SETUP_CYC`, 2, RS/data valid before EN rises
- `PULSE_CYC`, 4, EN high width
- `HOLD_CYC`, 2, RS/data held after EN falls
- `WAIT_CYC`, 8, execution wait for a normal command or data byte
- `WAIT_LONG_CYC`, 32, execution wait for commands 0x01 (clear) and 0x02/0x03 (home)

Ports:
- `i_clk`  in  1  clock, rising edge
- `i_reset`  in  1  synchronous, active-low reset
- `i_req_vld`  in  1  byte request valid
- `i_req_rs`  in  1  0 = command, 1 = data
- `i_req_data`  in  8  byte to send
- `o_req_rdy`  out  1  controller can accept a request this cycle
- `o_busy`  out  1  state ≠ IDLE
- `o_init_done`  out  1  init sequence complete (sticky until reset)
- `o_io_lcd`  out  32  bit31 ON, bit10 RS, bit9 RW (always 0), bit8 EN, bits7:0 DATA; other bits 0

## Operation

- States: POWERUP, SETUP, PULSE, HOLD, WAIT, IDLE. One down-counter, wide enough for the largest parameter, reloaded on every state entry.
- Reset (`i_reset`=0 sampled at an edge):
  - state = POWERUP, counter = POWERUP_CYC, init index = 0.
  - `o_io_lcd` = 0x0000_0000.
  - `o_req_rdy` = 0, `o_init_done` = 0, `o_busy` = 1.
- POWERUP:
  - `o_io_lcd` = 0x8000_0000.
  - After POWERUP_CYC cycles, load init byte 0 and go to SETUP.
- Init sequence (all RS=0): 0x38, 0x0C, 0x01, 0x06.
  - After the WAIT of each byte: load the next byte, or go to IDLE after 0x06.
  - `o_init_done` sets on entry to IDLE.
- SETUP: DATA and RS driven, EN=0.
- PULSE: EN=1, DATA and RS unchanged.
- HOLD: EN=0, DATA and RS unchanged.
- WAIT: EN=0, DATA and RS unchanged.
  - Duration is WAIT_LONG_CYC when RS=0 and DATA ∈ {0x01, 0x02, 0x03}, else WAIT_CYC.
- IDLE:
  - `o_req_rdy` = 1, `o_busy` = 0.
  - `o_io_lcd` keeps the last RS/DATA with EN=0, ON=1.
- Handshake:
  - Accept on a rising edge with `i_req_vld`=1 and `o_req_rdy`=1.
  - RS and data are registered at acceptance; input changes afterwards have no effect.
  - Next state is SETUP.
  - `i_req_vld` while not ready is ignored and is not queued. The requester holds its request until accepted.
- ON bit: 1 in every state except during reset.

## Timing

- Each state lasts exactly its parameter count in cycles.
- Transfer length is SETUP_CYC+PULSE_CYC+HOLD_CYC+wait: 16 cycles by default, 40 cycles for a long command.
- Accept-to-SETUP: 1 cycle (SETUP is visible on `o_io_lcd` the cycle after the accepting edge).
- Back-to-back: `o_req_rdy` is high in the first IDLE cycle. The maximum rate is one byte per transfer length + 1 cycles.
- Init completion with defaults: 20 + 3×16 + 40 = 108 cycles after the first edge sampling `i_reset`=1. `o_init_done` and `o_req_rdy` rise together.
- Reset mid-transfer or mid-init:
  - At the next edge, `o_io_lcd` = 0 and EN drops immediately.
  - The in-flight byte is abandoned and the full POWERUP/init sequence restarts.
- `o_busy` and `o_req_rdy` are complementary at all times.

## Test plan

- Reset release, no requests:
  - `o_io_lcd` = 0 during reset, then 0x8000_0000 for 20 cycles.
  - Then 0x38, 0x0C, 0x01, 0x06 appear with EN high for exactly 4 cycles each.
  - The 0x01 wait is 32 cycles.
  - `o_init_done` = `o_req_rdy` = 1 at cycle 108.
- Data write after init (vld, rs=1, data=0x41):
  - `o_io_lcd` goes 0x8000_0441 (2 cycles), 0x8000_0541 (4 cycles), then 0x8000_0441 (2+8 cycles).
  - Then IDLE with `o_req_rdy`=1.
- Clear command (rs=0, data=0x01) → WAIT lasts 32 cycles; total busy = 40 cycles.
- `i_req_vld` held continuously with data 0x48 then 0x49 → two transfers. The second is accepted in the first IDLE cycle after the first: 17-cycle spacing between EN rising edges.
- `i_req_vld`=1 during init, data=0x55 → not accepted before cycle 108. It is accepted on the first ready edge; no 0x55 appears on DATA earlier.
- `i_reset`=0 while EN=1 in a data transfer → `o_io_lcd` = 0 next cycle, `o_init_done`=0. After release, the full 108-cycle init replays.
